// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_defs_pkg
//  Purpose  : Shared ALU control codes, MIPS opcode/funct values and the
//             issue-bundle type passed from decode to the issue registers.
//  Revision : 1.0  initial release
// ============================================================================
package alu_defs_pkg;

    // 5-bit ALU operation codes
    localparam logic [4:0] c_alu_add     = 5'b00000;
    localparam logic [4:0] c_alu_sub     = 5'b00001;
    localparam logic [4:0] c_alu_and     = 5'b00010;
    localparam logic [4:0] c_alu_or      = 5'b00011;
    localparam logic [4:0] c_alu_sra     = 5'b00100;
    localparam logic [4:0] c_alu_srl     = 5'b00101;
    localparam logic [4:0] c_alu_sll     = 5'b00110;
    localparam logic [4:0] c_alu_sllv    = 5'b00111;
    localparam logic [4:0] c_alu_slt     = 5'b01000;
    localparam logic [4:0] c_alu_addi    = 5'b01001;
    localparam logic [4:0] c_alu_addiu   = 5'b01010;
    localparam logic [4:0] c_alu_andi    = 5'b01011;
    localparam logic [4:0] c_alu_ori     = 5'b01100;
    localparam logic [4:0] c_alu_lui     = 5'b01101;
    localparam logic [4:0] c_alu_sltiu   = 5'b01110;
    localparam logic [4:0] c_alu_slti    = 5'b01111;
    localparam logic [4:0] c_alu_beq     = 5'b10000;
    localparam logic [4:0] c_alu_bne     = 5'b10001;
    localparam logic [4:0] c_alu_lw      = 5'b10010;
    localparam logic [4:0] c_alu_sw      = 5'b10011;
    localparam logic [4:0] c_alu_illegal = 5'b11111;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_addiu = 6'h09;
    localparam logic [5:0] c_opc_andi  = 6'h0C;
    localparam logic [5:0] c_opc_ori   = 6'h0D;
    localparam logic [5:0] c_opc_lui   = 6'h0F;
    localparam logic [5:0] c_opc_sltiu = 6'h0B;
    localparam logic [5:0] c_opc_slti  = 6'h0A;
    localparam logic [5:0] c_opc_beq   = 6'h04;
    localparam logic [5:0] c_opc_bne   = 6'h05;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_slt  = 6'h2A;

    // Everything the ALU/EX stage needs for one instruction
    typedef struct packed {
        logic [4:0]  control;
        logic [31:0] inner1;
        logic [31:0] inner2;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_eq;
        logic        branch_ne;
        logic        illegal;
    } issue_bundle_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_decode
//  Purpose  : Combinational decode of a MIPS instruction plus register read
//             data into an ALU issue bundle (control code and operands).
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_decode
    import alu_defs_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic [31:0]   rs_data,
    input  logic [31:0]   rt_data,
    output issue_bundle_t bundle
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic        w_unused_rs;
    logic        w_wb;

    assign w_opcode   = instr[31:26];
    assign w_rt       = instr[20:16];
    assign w_rd       = instr[15:11];
    assign w_shamt    = instr[10:6];
    assign w_funct    = instr[5:0];
    assign w_imm      = instr[15:0];
    assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zext = {16'h0000, w_imm};
    // The rs register number is consumed by the register file, not here
    assign w_unused_rs = ^instr[25:21];

    // Decode: start from the illegal bundle and overwrite for known encodings
    always_comb begin
        bundle         = '0;
        bundle.control = c_alu_illegal;
        bundle.inner1  = rs_data;
        bundle.inner2  = rt_data;
        bundle.illegal = 1'b1;
        w_wb           = 1'b0;
        case (w_opcode)
            c_opc_rtype: begin
                bundle.dest = w_rd;
                w_wb        = 1'b1;
                bundle.illegal = 1'b0;
                case (w_funct)
                    c_fn_add:  bundle.control = c_alu_add;
                    c_fn_sub:  bundle.control = c_alu_sub;
                    c_fn_and:  bundle.control = c_alu_and;
                    c_fn_or:   bundle.control = c_alu_or;
                    c_fn_sllv: bundle.control = c_alu_sllv;
                    c_fn_slt:  bundle.control = c_alu_slt;
                    c_fn_sra: begin
                        bundle.control = c_alu_sra;
                        bundle.inner1  = {27'd0, w_shamt};
                    end
                    c_fn_srl: begin
                        bundle.control = c_alu_srl;
                        bundle.inner1  = {27'd0, w_shamt};
                    end
                    c_fn_sll: begin
                        bundle.control = c_alu_sll;
                        bundle.inner1  = {27'd0, w_shamt};
                    end
                    default: begin
                        // Unknown funct: revert to the illegal bundle
                        bundle.dest    = 5'd0;
                        w_wb           = 1'b0;
                        bundle.illegal = 1'b1;
                    end
                endcase
            end
            c_opc_addi, c_opc_addiu, c_opc_slti, c_opc_sltiu: begin
                bundle.control = (w_opcode == c_opc_addi)  ? c_alu_addi  :
                                 (w_opcode == c_opc_addiu) ? c_alu_addiu :
                                 (w_opcode == c_opc_slti)  ? c_alu_slti  :
                                                             c_alu_sltiu;
                bundle.inner2  = w_imm_sext;
                bundle.dest    = w_rt;
                w_wb           = 1'b1;
                bundle.illegal = 1'b0;
            end
            c_opc_andi, c_opc_ori: begin
                bundle.control = (w_opcode == c_opc_andi) ? c_alu_andi : c_alu_ori;
                bundle.inner2  = w_imm_zext;
                bundle.dest    = w_rt;
                w_wb           = 1'b1;
                bundle.illegal = 1'b0;
            end
            c_opc_lui: begin
                bundle.control = c_alu_lui;
                bundle.inner1  = 32'd0;
                bundle.inner2  = w_imm_zext;
                bundle.dest    = w_rt;
                w_wb           = 1'b1;
                bundle.illegal = 1'b0;
            end
            c_opc_lw: begin
                bundle.control  = c_alu_lw;
                bundle.inner2   = w_imm_sext;
                bundle.dest     = w_rt;
                bundle.mem_read = 1'b1;
                w_wb            = 1'b1;
                bundle.illegal  = 1'b0;
            end
            c_opc_sw: begin
                bundle.control   = c_alu_sw;
                bundle.inner2    = w_imm_sext;
                bundle.mem_write = 1'b1;
                bundle.illegal   = 1'b0;
            end
            c_opc_beq: begin
                bundle.control   = c_alu_beq;
                bundle.branch_eq = 1'b1;
                bundle.illegal   = 1'b0;
            end
            c_opc_bne: begin
                bundle.control   = c_alu_bne;
                bundle.branch_ne = 1'b1;
                bundle.illegal   = 1'b0;
            end
            default: ;
        endcase
        // Writes to $zero are suppressed
        bundle.reg_write = w_wb && (bundle.dest != 5'd0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Decode/issue stage ahead of the 5-bit-control ALU. Decoded
//             bundles pass through a head/skid register pair so in_ready is
//             registered and never depends combinationally on out_ready.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
    import alu_defs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_control,
    output logic [31:0]      inner1,
    output logic [31:0]      inner2,
    output logic [4:0]       dest_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] illegal_count
);

    issue_bundle_t    w_dec;
    issue_bundle_t    r_head;
    issue_bundle_t    r_skid;
    logic             r_head_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic             w_accept;
    logic             w_drain;

    alu_issue_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .bundle  (w_dec)
    );

    // The skid slot being free is exactly the condition to take a new entry
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && !r_skid_valid && !flush;
    assign w_drain  = r_head_valid && out_ready;

    // Head/skid occupancy and data movement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_skid       <= '0;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                // Skid full implies in_ready was low, so no accept this cycle
                r_head       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_head       <= w_dec;
            end else begin
                r_head_valid <= 1'b0;
            end
        end else if (!r_head_valid) begin
            if (w_accept) begin
                r_head       <= w_dec;
                r_head_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    // Performance counters count every completed handshake, even under flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else if (w_drain) begin
            r_issued_cnt <= r_issued_cnt + 1'b1;
            if (r_head.illegal) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign out_valid     = r_head_valid;
    assign alu_control   = r_head.control;
    assign inner1        = r_head.inner1;
    assign inner2        = r_head.inner2;
    assign dest_reg      = r_head.dest;
    assign reg_write     = r_head.reg_write;
    assign mem_read      = r_head.mem_read;
    assign mem_write     = r_head.mem_write;
    assign branch_eq     = r_head.branch_eq;
    assign branch_ne     = r_head.branch_ne;
    assign illegal       = r_head.illegal;
    assign issued_count  = r_issued_cnt;
    assign illegal_count = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Scoreboard bench for alu_issue_stage with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  alu_control;
    logic [31:0] inner1;
    logic [31:0] inner2;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_eq;
    logic        branch_ne;
    logic        illegal;
    logic [31:0] issued_count;
    logic [31:0] illegal_count;

    alu_issue_stage #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_control   (alu_control),
        .inner1        (inner1),
        .inner2        (inner2),
        .dest_reg      (dest_reg),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .illegal       (illegal),
        .issued_count  (issued_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [79:0] sb[$];
    logic [79:0] mon_exp;
    logic [79:0] mon_act;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bundle layout {ctl, inner1, inner2, dest, rw, mr, mw, beq, bne, ill}
    function automatic logic [79:0] mk(input logic [4:0] ctl, input logic [31:0] i1,
                                       input logic [31:0] i2, input logic [4:0] d,
                                       input logic [5:0] flags);
        return {ctl, i1, i2, d, flags};
    endfunction

    // Monitor: every completed handshake must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_act = {alu_control, inner1, inner2, dest_reg, reg_write, mem_read,
                       mem_write, branch_eq, branch_ne, illegal};
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got %h expected nothing", mon_act);
            end else begin
                mon_exp = sb.pop_front();
                chk("bundle", mon_act, mon_exp);
            end
        end
    end

    // Called at posedge+1; holds the vector until accepted, then records it
    task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [79:0] exp);
        logic r;
        int   n;
        n        = 0;
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                sb.push_back(exp);
                break;
            end
            n++;
            if (n > 50) begin
                n_checks++;
                $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", i);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drained", 80'(sb.size()), 80'd0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 80'(out_valid), 80'd0);
        chk("rst_in_ready", 80'(in_ready), 80'd1);
        chk("rst_alu_control", 80'(alu_control), 80'd0);
        chk("rst_counts", {16'd0, issued_count, illegal_count}, 80'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Main decode patterns with continuous out_ready
        send(32'h00851020, 32'd7, 32'd9, mk(5'h00, 32'd7, 32'd9, 5'd2, 6'b100000));
        send(32'h00021903, 32'h11, 32'h80000000, mk(5'h04, 32'd4, 32'h80000000, 5'd3, 6'b100000));
        send(32'h2088FFFF, 32'd5, 32'd9, mk(5'h09, 32'd5, 32'hFFFFFFFF, 5'd8, 6'b100000));
        send(32'h3488FFFF, 32'd5, 32'd9, mk(5'h0C, 32'd5, 32'h0000FFFF, 5'd8, 6'b100000));
        send(32'h00851022, 32'd20, 32'd3, mk(5'h01, 32'd20, 32'd3, 5'd2, 6'b100000));
        send(32'h8C880004, 32'h100, 32'h55, mk(5'h12, 32'h100, 32'd4, 5'd8, 6'b110000));
        send(32'hAC880004, 32'h100, 32'h55, mk(5'h13, 32'h100, 32'd4, 5'd0, 6'b001000));
        send(32'h10850003, 32'd1, 32'd1, mk(5'h10, 32'd1, 32'd1, 5'd0, 6'b000100));
        send(32'h14850003, 32'd1, 32'd2, mk(5'h11, 32'd1, 32'd2, 5'd0, 6'b000010));
        send(32'h3C081234, 32'h99, 32'h5, mk(5'h0D, 32'd0, 32'h1234, 5'd8, 6'b100000));
        send(32'h00850020, 32'd7, 32'd9, mk(5'h00, 32'd7, 32'd9, 5'd0, 6'b000000));
        send(32'h0085102A, 32'd3, 32'd4, mk(5'h08, 32'd3, 32'd4, 5'd2, 6'b100000));
        wait_empty();
        chk("issued_count_12", 80'(issued_count), 80'd12);

        // Backpressure: two entries fill H and S, the third waits
        out_ready = 1'b0;
        send(32'h00041080, 32'd0, 32'd3, mk(5'h06, 32'd2, 32'd3, 5'd2, 6'b100000));
        send(32'h00041042, 32'd0, 32'h10, mk(5'h05, 32'd1, 32'h10, 5'd2, 6'b100000));
        fork
            send(32'h00851004, 32'd6, 32'd1, mk(5'h07, 32'd6, 32'd1, 5'd2, 6'b100000));
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 80'(in_ready), 80'd0);
                    chk("bp_count_held", 80'(issued_count), 80'd12);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();
        chk("issued_count_15", 80'(issued_count), 80'd15);

        // Flush with H and S full and a pending input
        out_ready = 1'b0;
        send(32'h00851020, 32'd1, 32'd1, mk(5'h00, 32'd1, 32'd1, 5'd2, 6'b100000));
        send(32'h00851022, 32'd1, 32'd1, mk(5'h01, 32'd1, 32'd1, 5'd2, 6'b100000));
        instr    = 32'h00851024;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 80'(out_valid), 80'd0);
        chk("flush_in_ready", 80'(in_ready), 80'd1);

        // Flush beats an accept that would otherwise land in empty H
        send(32'h00851020, 32'd1, 32'd1, mk(5'h00, 32'd1, 32'd1, 5'd2, 6'b100000));
        instr    = 32'h00851025;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("flush_drop_accept", 80'(out_valid), 80'd0);
        chk("flush_nothing_issued", 80'(issued_count), 80'd15);
        @(posedge clk);
        #1;

        // Illegal encoding
        send(32'hFC000000, 32'h33, 32'h44, mk(5'h1F, 32'h33, 32'h44, 5'd0, 6'b000001));
        wait_empty();
        chk("illegal_count", 80'(illegal_count), 80'd1);
        chk("issued_count_16", 80'(issued_count), 80'd16);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h2088FFFF, 32'd5, 32'd9, mk(5'h09, 32'd5, 32'hFFFFFFFF, 5'd8, 6'b100000));
        send(32'h3488FFFF, 32'd5, 32'd9, mk(5'h0C, 32'd5, 32'h0000FFFF, 5'd8, 6'b100000));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid_ready", {78'd0, out_valid, in_ready}, 80'd1);
        chk("arst_data", {alu_control, inner1, inner2, dest_reg, reg_write, mem_read,
                          mem_write, branch_eq, branch_ne, illegal}, 80'd0);
        chk("arst_counts", {16'd0, issued_count, illegal_count}, 80'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        base = 0;
        send(32'h00851020, 32'd7, 32'd9, mk(5'h00, 32'd7, 32'd9, 5'd2, 6'b100000));
        wait_empty();
        chk("post_reset_count", 80'(issued_count), 80'(base + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that sits directly upstream of the 5-bit-control ALU.
- Accepts a fetched MIPS instruction plus register-file read data, then decodes the ALU control code.
- Builds the two ALU operands (inner1/inner2) using the ALU's operand conventions.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the ALU/EX side may stall without a combinational ready path back to fetch.

Parameters:
- CNT_W, 32, width of the issued and illegal performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries (branch taken).
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  stage can accept; registered (not a function of out_ready).
- instr  in  32  MIPS instruction word.
- rs_data  in  32  register file read port A.
- rt_data  in  32  register file read port B.
- out_valid  out  1  issued bundle valid.
- out_ready  in  1  ALU/EX stage accepts.
- alu_control  out  5  ALU operation code.
- inner1  out  32  ALU operand 1.
- inner2  out  32  ALU operand 2.
- dest_reg  out  5  writeback register.
- reg_write  out  1  writeback enable.
- mem_read  out  1  LW.
- mem_write  out  1  SW.
- branch_eq  out  1  BEQ.
- branch_ne  out  1  BNE.
- illegal  out  1  unsupported encoding.
- issued_count  out  CNT_W  count of out_valid&&out_ready handshakes.
- illegal_count  out  CNT_W  count of issued illegal bundles.

Behaviour:
- Decode is combinational on the input side; outputs are always driven from the head register.
- R-type (op=0), funct to alu_control:
  - 20h ADD→00000, 22h SUB→00001, 24h AND→00010, 25h OR→00011, 03h SRA→00100, 02h SRL→00101, 00h SLL→00110, 04h SLLV→00111, 2Ah SLT→01000.
- I-type opcodes to alu_control:
  - 08h ADDI→01001, 09h ADDIU→01010, 0Ch ANDI→01011, 0Dh ORI→01100, 0Fh LUI→01101, 0Bh SLTIU→01110, 0Ah SLTI→01111, 04h BEQ→10000, 05h BNE→10001, 23h LW→10010, 2Bh SW→10011.
- Operand construction:
  - ADD/SUB/AND/OR/SLT/SLLV/BEQ/BNE: inner1=rs_data, inner2=rt_data.
  - SRA/SRL/SLL: inner1={27'b0,shamt}, inner2=rt_data.
  - ADDI/ADDIU/SLTI/SLTIU/LW/SW: inner1=rs_data, inner2=sign-extended imm16.
  - ANDI/ORI: inner1=rs_data, inner2=zero-extended imm16.
  - LUI: inner1=0, inner2=zero-extended imm16.
- Destination and flags:
  - dest_reg=rd for R-type; rt for ALU-immediate and LW; 0 for SW/BEQ/BNE.
  - reg_write=1 only for R-type, ALU-immediate and LW, and only when dest_reg≠0.
- Illegal encoding: any other opcode/funct gives alu_control=11111, inner1=rs_data, inner2=rt_data, all side-effect flags 0, illegal=1.
- Buffering: head register H (drives outputs) and skid register S; in_ready = !S.valid.
  - Accept when in_valid && in_ready.
  - Drain when out_valid && out_ready.
  - Accept with H empty, or H draining and S empty: load H.
  - Accept with H holding and not draining: load S.
  - Drain with S full: S→H, S empties.
- Latency: 1 cycle from accept to out_valid. Throughput: 1/cycle under continuous out_ready.
- flush: next edge H.valid=S.valid=0 and in_ready=1. Flush beats a simultaneous accept, which is dropped. A drain in the same cycle still counts in issued_count.
- Counters: increment on drain; illegal_count increments when a drained bundle has illegal=1. Both wrap modulo 2^CNT_W.
- Reset (async, rst_n=0): H.valid=S.valid=0, in_ready=1, all data outputs and counters 0, alu_control=00000. Reset mid-transfer discards all entries.

Decomposition:
- Shared package alu_defs_pkg: 5-bit ALU op constants (ADD..SW, ILLEGAL=11111), opcode and funct constants, issue-bundle struct (control, inner1, inner2, dest, flags).
- One sub-module, alu_issue_decode: pure combinational instr/rs/rt → bundle.
- Top level holds the H/S registers, handshake and counters.

Test Plan:
- ADD: instr 0x00851020 (add $2,$4,$5), rs=7, rt=9, out_ready=1 → next cycle out_valid=1, alu_control=00000, inner1=7, inner2=9, dest_reg=2, reg_write=1.
- SRA: instr 0x00021903 (sra $3,$2,4), rt=0x80000000 → alu_control=00100, inner1=4, inner2=0x80000000.
- ADDI: instr 0x2088FFFF (addi $8,$4,-1) → inner2=0xFFFFFFFF.
- ORI: instr 0x3488FFFF (ori $8,$4,0xFFFF) → inner2=0x0000FFFF, alu_control=01100.
- Backpressure: out_ready=0, feed 3 back-to-back → first in H, second in S, in_ready=0 with third held. Raise out_ready → drains in order, issued_count=3, no loss or duplication.
- Flush and illegal: flush with H and S full plus in_valid=1 → next cycle out_valid=0, in_ready=1, nothing issued. Then instr 0xFC000000 → illegal=1, alu_control=11111, reg_write=0, illegal_count=1. Assert rst_n=0 mid-stream → all outputs 0 immediately.
